// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus command, requester enum and memory tag width
package mem_bus_arbiter_pkg;

    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_ICACHE = 2'd1,
        REQ_DCACHE = 2'd2
    } MEM_REQUESTER;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - cache/memory bus bundle seen by the arbiter
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TAG_W = MEM_TAG_W
);
    BUS_COMMAND         Icache2mem_command;
    logic [63:0]        Icache2mem_addr;
    BUS_COMMAND         Dcache2mem_command;
    logic [63:0]        Dcache2mem_addr;
    logic [63:0]        Dcache2mem_data;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [TAG_W-1:0]   mem2proc_tag;
    logic [63:0]        mem2proc_data;

    BUS_COMMAND         proc2mem_command;
    logic [63:0]        proc2mem_addr;
    logic [63:0]        proc2mem_data;
    logic [TAG_W-1:0]   mem2Icache_response;
    logic [TAG_W-1:0]   mem2Icache_tag;
    logic [TAG_W-1:0]   mem2Dcache_response;
    logic [TAG_W-1:0]   mem2Dcache_tag;
    logic [63:0]        mem2cache_data;
    logic               stray_tag_err;

    // master: the arbiter itself; slave: caches plus memory around it
    modport master (
        input  Icache2mem_command, Icache2mem_addr,
        input  Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2Icache_response, mem2Icache_tag,
        output mem2Dcache_response, mem2Dcache_tag,
        output mem2cache_data, stray_tag_err
    );

    modport slave (
        output Icache2mem_command, Icache2mem_addr,
        output Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2Icache_response, mem2Icache_tag,
        input  mem2Dcache_response, mem2Dcache_tag,
        input  mem2cache_data, stray_tag_err
    );
endinterface

// File: rtl/mem_bus_arbiter_owner_table.sv
// rtl/mem_bus_arbiter_owner_table.sv - per-tag owner record for outstanding loads
module mem_tag_owner_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TAG_W = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic             set_is_dcache_i,
    input  logic [TAG_W-1:0] lk_tag_i,
    output logic             lk_valid_o,
    output logic             lk_is_dcache_o
);
    localparam int DEPTH = 2 ** TAG_W;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] is_dcache_q;

    assign lk_valid_o     = (lk_tag_i != '0) && valid_q[lk_tag_i];
    assign lk_is_dcache_o = is_dcache_q[lk_tag_i];

    // The set is written after the clear so a new load reusing a returning tag keeps its entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            is_dcache_q <= '0;
        end else begin
            if (lk_valid_o)
                valid_q[lk_tag_i] <= 1'b0;
            if (set_en_i) begin
                valid_q[set_tag_i]     <= 1'b1;
                is_dcache_q[set_tag_i] <= set_is_dcache_i;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - icache/dcache arbiter for the tagged main-memory port
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_DCACHE_BURST = 4,
    parameter int TAG_W            = MEM_TAG_W
) (
    input logic               clock,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    localparam int BURST_W = $clog2(MAX_DCACHE_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DCACHE_BURST);

    MEM_REQUESTER     grant;
    logic             ic_active;
    logic             dc_active;
    logic             accepted;
    logic [TAG_W-1:0] ret_tag;
    logic             lk_valid;
    logic             lk_is_dcache;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic             stray_q, stray_d;

    // An icache store is illegal and simply never requests.
    assign ic_active = (bus.Icache2mem_command == BUS_LOAD);
    assign dc_active = (bus.Dcache2mem_command == BUS_LOAD) ||
                       (bus.Dcache2mem_command == BUS_STORE);

    // While reset is held every output is forced quiet, not just the registered state.
    always_comb begin
        grant = REQ_NONE;
        if (reset) begin
            if (ic_active && dc_active)
                grant = (burst_q == BURST_MAX) ? REQ_ICACHE : REQ_DCACHE;
            else if (dc_active)
                grant = REQ_DCACHE;
            else if (ic_active)
                grant = REQ_ICACHE;
        end
    end

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        case (grant)
            REQ_ICACHE: begin
                bus.proc2mem_command = BUS_LOAD;
                bus.proc2mem_addr    = bus.Icache2mem_addr;
            end
            REQ_DCACHE: begin
                bus.proc2mem_command = bus.Dcache2mem_command;
                bus.proc2mem_addr    = bus.Dcache2mem_addr;
                bus.proc2mem_data    = bus.Dcache2mem_data;
            end
            default: ;
        endcase
    end

    assign accepted = (grant != REQ_NONE) && (bus.mem2proc_response != '0);

    assign bus.mem2Icache_response = (grant == REQ_ICACHE) ? bus.mem2proc_response : '0;
    assign bus.mem2Dcache_response = (grant == REQ_DCACHE) ? bus.mem2proc_response : '0;

    assign ret_tag            = reset ? bus.mem2proc_tag : '0;
    assign bus.mem2cache_data = reset ? bus.mem2proc_data : '0;

    mem_tag_owner_table #(
        .TAG_W (TAG_W)
    ) u_owner (
        .clock           (clock),
        .reset           (reset),
        .set_en_i        (accepted && (bus.proc2mem_command == BUS_LOAD)),
        .set_tag_i       (bus.mem2proc_response),
        .set_is_dcache_i (grant == REQ_DCACHE),
        .lk_tag_i        (ret_tag),
        .lk_valid_o      (lk_valid),
        .lk_is_dcache_o  (lk_is_dcache)
    );

    assign bus.mem2Icache_tag = (lk_valid && !lk_is_dcache) ? ret_tag : '0;
    assign bus.mem2Dcache_tag = (lk_valid &&  lk_is_dcache) ? ret_tag : '0;
    assign stray_d            = (ret_tag != '0) && !lk_valid;
    assign bus.stray_tag_err  = stray_q;

    always_comb begin
        burst_d = burst_q;
        if (accepted && grant == REQ_ICACHE)
            burst_d = '0;
        else if (!ic_active)
            burst_d = '0;
        else if (accepted && grant == REQ_DCACHE && burst_q != BURST_MAX)
            burst_d = burst_q + BURST_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
            stray_q <= 1'b0;
        end else begin
            burst_q <= burst_d;
            stray_q <= stray_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.TAG_W(4)) bif ();

    mem_bus_arbiter #(
        .MAX_DCACHE_BURST (4),
        .TAG_W            (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input BUS_COMMAND ic_cmd, input logic [63:0] ic_addr,
                         input BUS_COMMAND dc_cmd, input logic [63:0] dc_addr,
                         input logic [63:0] dc_data, input logic [3:0] resp,
                         input logic [3:0] rtag, input logic [63:0] rdata);
        bif.Icache2mem_command = ic_cmd;
        bif.Icache2mem_addr    = ic_addr;
        bif.Dcache2mem_command = dc_cmd;
        bif.Dcache2mem_addr    = dc_addr;
        bif.Dcache2mem_data    = dc_data;
        bif.mem2proc_response  = resp;
        bif.mem2proc_tag       = rtag;
        bif.mem2proc_data      = rdata;
    endtask

    task automatic idle();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        idle();
        #3;
        expect_eq("rst_cmd",   bif.proc2mem_command, BUS_NONE);
        expect_eq("rst_addr",  bif.proc2mem_addr, 64'h0);
        expect_eq("rst_stray", bif.stray_tag_err, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // icache load alone, later returned
        drive(BUS_LOAD, 64'h1000, BUS_NONE, 64'h0, 64'h0, 4'd3, 4'd0, 64'h0);
        #3;
        expect_eq("t1_addr",  bif.proc2mem_addr, 64'h1000);
        expect_eq("t1_cmd",   bif.proc2mem_command, BUS_LOAD);
        expect_eq("t1_iresp", bif.mem2Icache_response, 4'd3);
        expect_eq("t1_dresp", bif.mem2Dcache_response, 4'd0);
        next(); idle(); next();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD);
        #3;
        expect_eq("t1_itag", bif.mem2Icache_tag, 4'd3);
        expect_eq("t1_dtag", bif.mem2Dcache_tag, 4'd0);
        expect_eq("t1_data", bif.mem2cache_data, 64'hDEAD);
        next(); idle(); #3;
        expect_eq("t1_nostray", bif.stray_tag_err, 1'b0);

        // both request, dcache store wins, its tag later returns as stray
        next();
        drive(BUS_LOAD, 64'h3000, BUS_STORE, 64'h2000, 64'h55, 4'd5, 4'd0, 64'h0);
        #3;
        expect_eq("t2_cmd",   bif.proc2mem_command, BUS_STORE);
        expect_eq("t2_addr",  bif.proc2mem_addr, 64'h2000);
        expect_eq("t2_data",  bif.proc2mem_data, 64'h55);
        expect_eq("t2_dresp", bif.mem2Dcache_response, 4'd5);
        expect_eq("t2_iresp", bif.mem2Icache_response, 4'd0);
        next(); idle(); next();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'h77);
        #3;
        expect_eq("t2_itag", bif.mem2Icache_tag, 4'd0);
        expect_eq("t2_dtag", bif.mem2Dcache_tag, 4'd0);
        next(); idle(); #3;
        expect_eq("t2_stray1", bif.stray_tag_err, 1'b1);
        next(); #3;
        expect_eq("t2_stray0", bif.stray_tag_err, 1'b0);

        // continuous contention: D D D D I D D D D I
        next();
        for (int i = 0; i < 10; i++) begin
            drive(BUS_LOAD, 64'h4000, BUS_STORE, 64'h5000, 64'h11, 4'd9, 4'd0, 64'h0);
            #3;
            expect_eq($sformatf("t3_grant%0d", i), bif.proc2mem_addr,
                      exp_i[i] ? 64'h4000 : 64'h5000);
            next();
        end
        idle(); next();

        // rejected dcache loads must not advance the burst count
        for (int i = 0; i < 3; i++) begin
            drive(BUS_LOAD, 64'h4000, BUS_STORE, 64'h5000, 64'h22, 4'd1, 4'd0, 64'h0);
            #3;
            expect_eq($sformatf("t4_pre%0d", i), bif.proc2mem_addr, 64'h5000);
            next();
        end
        for (int i = 0; i < 3; i++) begin
            drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h6000, 64'h0, 4'd0, 4'd0, 64'h0);
            #3;
            expect_eq($sformatf("t4_rej_addr%0d", i), bif.proc2mem_addr, 64'h6000);
            expect_eq($sformatf("t4_rej_resp%0d", i), bif.mem2Dcache_response, 4'd0);
            next();
        end
        drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h6000, 64'h0, 4'd7, 4'd0, 64'h0);
        #3;
        expect_eq("t4_acc_addr", bif.proc2mem_addr, 64'h6000);
        expect_eq("t4_acc_resp", bif.mem2Dcache_response, 4'd7);
        next();
        drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h6000, 64'h0, 4'd0, 4'd0, 64'h0);
        #3;
        expect_eq("t4_forced_i", bif.proc2mem_addr, 64'h4000);
        next(); idle(); next();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'h1234);
        #3;
        expect_eq("t4_dtag", bif.mem2Dcache_tag, 4'd7);
        expect_eq("t4_itag", bif.mem2Icache_tag, 4'd0);
        next(); idle(); next();

        // tag 2 returns to icache while being reissued to dcache
        drive(BUS_LOAD, 64'h7000, BUS_NONE, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
        next(); idle(); next();
        drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h8000, 64'h0, 4'd2, 4'd2, 64'hAAAA);
        #3;
        expect_eq("t5_itag",  bif.mem2Icache_tag, 4'd2);
        expect_eq("t5_dtag",  bif.mem2Dcache_tag, 4'd0);
        expect_eq("t5_dresp", bif.mem2Dcache_response, 4'd2);
        next(); idle(); next();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd2, 64'hBBBB);
        #3;
        expect_eq("t5_dtag2", bif.mem2Dcache_tag, 4'd2);
        expect_eq("t5_itag2", bif.mem2Icache_tag, 4'd0);
        next(); idle(); #3;
        expect_eq("t5_nostray", bif.stray_tag_err, 1'b0);

        // reset with tags 1 and 4 in flight
        next();
        drive(BUS_LOAD, 64'hA000, BUS_NONE, 64'h0, 64'h0, 4'd1, 4'd0, 64'h0);
        next();
        drive(BUS_NONE, 64'h0, BUS_LOAD, 64'hB000, 64'h0, 4'd4, 4'd0, 64'h0);
        next();
        drive(BUS_LOAD, 64'hC000, BUS_NONE, 64'h0, 64'h0, 4'd6, 4'd1, 64'hBEEF);
        #1;
        expect_eq("t6_pre_itag", bif.mem2Icache_tag, 4'd1);
        reset = 1'b0;
        #1;
        expect_eq("t6_cmd",   bif.proc2mem_command, BUS_NONE);
        expect_eq("t6_addr",  bif.proc2mem_addr, 64'h0);
        expect_eq("t6_iresp", bif.mem2Icache_response, 4'd0);
        expect_eq("t6_itag",  bif.mem2Icache_tag, 4'd0);
        expect_eq("t6_data",  bif.mem2cache_data, 64'h0);
        expect_eq("t6_stray", bif.stray_tag_err, 1'b0);
        idle();
        next();
        reset = 1'b1;
        next();
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd4, 64'h44);
        #3;
        expect_eq("t6_dtag4", bif.mem2Dcache_tag, 4'd0);
        expect_eq("t6_itag4", bif.mem2Icache_tag, 4'd0);
        next(); idle(); #3;
        expect_eq("t6_stray1", bif.stray_tag_err, 1'b1);
        next(); #3;
        expect_eq("t6_stray0", bif.stray_tag_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
